// File: rtl/ssp_pkg.sv
// Shared SSP definitions: word width, FIFO depth and derived types.
// The talker, the transmit FIFO and the receive FIFO all use them.
package ssp_pkg;

    localparam int SSP_WORD_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;
    localparam int SSP_PTR_W      = $clog2(SSP_FIFO_DEPTH);
    localparam int SSP_CNT_W      = SSP_PTR_W + 1;

    typedef logic [SSP_WORD_W-1:0] ssp_word_t;

endpackage

// File: rtl/ssp_txfifo_if.sv
// Host push / talker pop bundle for the SSP transmit FIFO.
// The master side drives the requests, and the slave (the FIFO) drives the head word and the flags.
interface ssp_txfifo_if
    import ssp_pkg::*;
#(
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int WIDTH = SSP_WORD_W
);

    logic                     wr_en;
    logic [WIDTH-1:0]         wdata;
    logic                     rd_en;
    logic                     ovr_clr;
    logic [WIDTH-1:0]         txdata;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     txintr;
    logic                     overrun;

    modport master (
        output wr_en, wdata, rd_en, ovr_clr,
        input  txdata, empty, full, count, txintr, overrun
    );

    modport slave (
        input  wr_en, wdata, rd_en, ovr_clr,
        output txdata, empty, full, count, txintr, overrun
    );

endinterface

// File: rtl/ssp_fifo_regs.sv
// FIFO storage: one synchronous write port and one asynchronous read port, cleared to zero.
// The transmit FIFO and the receive FIFO both use this module.
module ssp_fifo_regs
    import ssp_pkg::*;
#(
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int WIDTH = SSP_WORD_W
) (
    input  logic                     pclk,
    input  logic                     clear,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: cleared as a whole on clear, otherwise one slot is written per push.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            mem_r <= '{default: '0};
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ssp_txfifo.sv
// First-word-fall-through transmit FIFO that feeds the SSP talker.
// Occupancy is held in its own counter. The flags and the half-empty request are decoded from it.
module ssp_txfifo
    import ssp_pkg::*;
#(
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int WIDTH = SSP_WORD_W
) (
    input  logic          pclk,
    input  logic          clear,
    ssp_txfifo_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wp_r;
    logic [PTR_W-1:0] rp_r;
    logic [CNT_W-1:0] count_r;
    logic             overrun_r;

    logic             empty_s;
    logic             full_s;
    logic             txintr_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [WIDTH-1:0] head_s;

    // Flag decode and accept logic. When the FIFO is full, a push is still taken if a pop frees a slot on the same edge.
    always_comb begin
        empty_s     = (count_r == CNT_W'(0));
        full_s      = (count_r == CNT_W'(DEPTH));
        txintr_s    = (count_r <= CNT_W'(DEPTH / 2));
        push_s      = bus.wr_en & (~full_s | bus.rd_en);
        pop_s       = bus.rd_en & ~empty_s;
        drop_s      = bus.wr_en & full_s & ~bus.rd_en;
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers and occupancy. Because DEPTH is a power of two, the pointers wrap on their own.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            wp_r    <= '0;
            rp_r    <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_W'(1);
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky overrun flag. A dropped push takes priority over a clear request in the same cycle.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_r <= 1'b0;
        end
    end

    ssp_fifo_regs #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regs (
        .pclk  (pclk),
        .clear (clear),
        .we    (push_s),
        .waddr (wp_r),
        .wdata (bus.wdata),
        .raddr (rp_r),
        .rdata (head_s)
    );

    assign bus.txdata  = head_s;
    assign bus.empty   = empty_s;
    assign bus.full    = full_s;
    assign bus.count   = count_r;
    assign bus.txintr  = txintr_s;
    assign bus.overrun = overrun_r;

endmodule

// File: doc/ssp_txfifo.md
# ssp_txfifo

Transmit buffer directly upstream of the SSP talker: the host side pushes 8-bit words, and the talker pops them one per frame from the `txdata` head. It is a first-word-fall-through FIFO with registered occupancy flags, a half-empty service request and a sticky overrun flag. It runs on the same `pclk` as the talker.

## Interface
- `DEPTH`, 4: number of word slots; must be a power of two, minimum 2.
- `WIDTH`, 8: word width in bits; matches talker `txdata`.
- `pclk` input 1: SSP clock; all state changes on its rising edge.
- `clear` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: push request for `wdata`.
- `wdata` input WIDTH: word to push.
- `rd_en` input 1: pop request from the talker, one cycle per word consumed.
- `ovr_clr` input 1: clears the sticky `overrun` flag.
- `txdata` output WIDTH: head word; valid whenever `empty`=0.
- `empty` output 1: no words stored.
- `full` output 1: DEPTH words stored.
- `count` output log2(DEPTH)+1: number of words stored, 0..DEPTH.
- `txintr` output 1: service request; high when `count` <= DEPTH/2.
- `overrun` output 1: sticky; set by a push that was dropped.

## Operation
- Storage: DEPTH x WIDTH register array, write pointer `wp`, read pointer `rp`, each log2(DEPTH) bits wide. Pointers wrap modulo DEPTH (from DEPTH-1 to 0) with no gap.
- `count` is held as its own register. `empty`, `full` and `txintr` are decoded from `count`.
- `txdata` = array[`rp`], combinational from the registers. No read latency.
- Push is accepted when `wr_en` and (not `full` or `rd_en`). On accept: array[`wp`] <= `wdata`, `wp`++.
- Pop is accepted when `rd_en` and not `empty`. On accept: `rp`++.
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Full with `wr_en` and `rd_en` together: both are accepted and `count` stays DEPTH.
- Empty with `wr_en` and `rd_en` together: the push is accepted, the pop is ignored, and `count` becomes 1.
- `rd_en` while empty (alone): no effect, no error flag.
- `wr_en` while full without `rd_en`: the word is dropped, nothing else changes, and `overrun` <= 1.
- `overrun`:
  - Cleared only by `ovr_clr` or `clear`.
  - If `ovr_clr` and a dropped push occur in the same cycle, set wins.
- `clear` asserted at any time, including mid-burst, aborts everything immediately:
  - Pointers, `count`, `overrun` and the whole array go to 0.
  - Any words in flight are lost.

## Timing
- Reset values: `txdata`=0x00, `empty`=1, `full`=0, `count`=0, `txintr`=1, `overrun`=0.
- Push at edge N: `count`, `empty` and `full` update after edge N. If the FIFO was empty, `txdata` shows the new word in cycle N+1.
- Pop at edge N: the next word is on `txdata` in cycle N+1.
- Maximum throughput is one push and one pop per cycle.
- All flags are registered or decoded from registers. There are no combinational paths from inputs to `empty`, `full`, `count` or `txintr`.
- `txdata` depends only on registers, so the talker can latch it on the same edge it asserts `rd_en`.

## Structure
- Shared package `ssp_pkg` holds:
  - `SSP_WORD_W`=8 and `SSP_FIFO_DEPTH`=4.
  - A derived `SSP_PTR_W` and a `ssp_word_t` typedef.
  - These are reused by the talker and the future receive FIFO.
- Sub-module `ssp_fifo_regs` is the natural split:
  - Contents: the register array with write port (`we`, `waddr`, `wdata`) and async read port (`raddr` -> `rdata`), plus reset-to-zero.
  - Reuse: the receive FIFO uses the same sub-module.
  - Pointer, count and flag control stays in `ssp_txfifo`.

## Test plan
- Reset then idle:
  - Stimulus: assert `clear` mid-cycle.
  - Required: all outputs at their reset values immediately, without waiting for a `pclk` edge. `rd_en` pulses cause no change.
- Fill and drain:
  - Stimulus: push 0xA1, 0xB2, 0xC3, 0xD4, then pop four times.
  - Required after the pushes: `count`=4, `full`=1, `txintr`=0.
  - Required during the pops: `txdata` is 0xA1, 0xB2, 0xC3, 0xD4 in order, then `empty`=1 and `txintr`=1.
  - `txintr` is high in every cycle with `count`<=2.
- Overrun:
  - Stimulus: fill to 4, push 0xEE without `rd_en`.
  - Required: `overrun`=1, contents unchanged, and the pops return the original 4 words.
  - Then pulse `ovr_clr` together with another dropped push: `overrun` stays 1. A lone `ovr_clr` then clears it.
- Simultaneous push and pop:
  - Full case: `count` stays 4, the head advances, and the new word appears 4th in order.
  - Empty case, with 0x5A: `count`=1 and `txdata`=0x5A next cycle.
- Wrap-around:
  - Stimulus: 10 interleaved push/pop cycles with a sequential data pattern, so the pointers wrap at least twice.
  - Required: the output sequence matches a reference queue exactly.
- Mid-burst clear:
  - Stimulus: with 3 words stored, assert `clear` during a push.
  - Required: `count`=0 and `empty`=1. After release, a push of 0x77 appears on `txdata` next cycle.
